// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and width limit for the bit-serial adder.
// Rev 1.0
`default_nettype none

package serial_adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder used by the serial datapath.
// Rev 1.0
`default_nettype none

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add/subtract with valid/ready handshakes.
// Rev 1.0
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction folds into addition as A + ~B + 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_c;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Rev 1.0
`default_nettype none

module tb_serial_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, sub1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;
  logic       pv8 = 1'b0, pv1 = 1'b0;

  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic on integers, signed overflow from range check.
  function automatic exp_t model(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                 input logic ci, input logic issub);
    exp_t        e;
    logic [64:0] mask, full;
    longint      sa, sbv, sr, lo, hi;
    mask = (65'd1 << w) - 65'd1;
    if (issub) full = ({1'b0, ia} & mask) + ((~{1'b0, ib}) & mask) + 65'd1;
    else       full = ({1'b0, ia} & mask) + ({1'b0, ib} & mask) + {64'd0, ci};
    e.s  = full[63:0] & mask[63:0];
    e.c  = full[w];
    sa   = longint'(ia & mask[63:0]);
    sbv  = longint'(ib & mask[63:0]);
    if (ia[w-1]) sa  = sa  - (longint'(1) << w);
    if (ib[w-1]) sbv = sbv - (longint'(1) << w);
    sr   = issub ? (sa - sbv) : (sa + sbv + longint'(ci));
    lo   = -(longint'(1) << (w - 1));
    hi   = (longint'(1) << (w - 1)) - 1;
    e.v  = (sr < lo) || (sr > hi);
    e.acc = 0;
    return e;
  endfunction

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
    chk("in_ready8_wait", {63'd0, in_ready8}, 64'd1);
    if (!in_ready8) return;
    a8 = ia; b8 = ib; cin8 = ic; sub8 = is; in_valid8 = 1'b1;
    e = model(8, {56'd0, ia}, {56'd0, ib}, ic, is);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue1(input logic ia, input logic ib, input logic ic, input logic is);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    chk("in_ready1_wait", {63'd0, in_ready1}, 64'd1);
    if (!in_ready1) return;
    a1 = ia; b1 = ib; cin1 = ic; sub1 = is; in_valid1 = 1'b1;
    e = model(1, {63'd0, ia}, {63'd0, ib}, ic, is);
    e.acc = cyc + 1;
    q1.push_back(e);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain", 64'(q8.size() + q1.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid8 && !pv8) begin
        chk("pending8_at_valid", {63'd0, q8.size() != 0}, 64'd1);
        if (q8.size() != 0) chk("latency8", 64'(cyc - q8[0].acc), 64'd8);
      end
      if (out_valid8 && out_ready8) begin
        chk("pending8_at_pop", {63'd0, q8.size() != 0}, 64'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("sum8", {56'd0, sum8}, e.s);
          chk("cout8", {63'd0, cout8}, {63'd0, e.c});
          chk("ovf8", {63'd0, ovf8}, {63'd0, e.v});
          chk("in_ready8_during_pop", {63'd0, in_ready8}, 64'd0);
        end
      end
    end
    pv8 <= out_valid8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid1 && !pv1) begin
        chk("pending1_at_valid", {63'd0, q1.size() != 0}, 64'd1);
        if (q1.size() != 0) chk("latency1", 64'(cyc - q1[0].acc), 64'd1);
      end
      if (out_valid1 && out_ready1) begin
        chk("pending1_at_pop", {63'd0, q1.size() != 0}, 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sum1", {63'd0, sum1}, e.s);
          chk("cout1", {63'd0, cout1}, {63'd0, e.c});
          chk("ovf1", {63'd0, ovf1}, {63'd0, e.v});
        end
      end
    end
    pv1 <= out_valid1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hs;
    logic       hc, hv;
    int         n;
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready8", {63'd0, in_ready8}, 64'd1);
    chk("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
    chk("rst_sum8", {56'd0, sum8}, 64'd0);
    chk("rst_flags8", {62'd0, cout8, ovf8}, 64'd0);
    chk("rst_in_ready1", {63'd0, in_ready1}, 64'd1);
    chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
    rst_n = 1'b1;

    issue8(8'h0F, 8'h01, 1'b0, 1'b0);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0);
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    issue8(8'h80, 8'h01, 1'b1, 1'b1);
    issue8(8'h80, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1 out_ready8 = 1'b0;
    issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    chk("stall_valid_seen", {63'd0, out_valid8}, 64'd1);
    hs = sum8; hc = cout8; hv = ovf8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {63'd0, out_valid8}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready8}, 64'd0);
      chk("stall_hold", {54'd0, sum8, cout8, ovf8}, {54'd0, hs, hc, hv});
    end
    @(posedge clk); #1 out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_pop_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("post_pop_out_valid", {63'd0, out_valid8}, 64'd0);

    // Abort mid-operation: reset while bit 3 is being processed.
    issue8(8'h3C, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("abort_sum", {56'd0, sum8}, 64'd0);
    chk("abort_flags", {62'd0, cout8, ovf8}, 64'd0);
    void'(q8.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'h01, 8'h01, 1'b0, 1'b0);
    drain();

    issue1(1'b1, 1'b1, 1'b0, 1'b0);
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    issue1(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      issue1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    chk("q8_empty", 64'(q8.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  0 = A+B+cin, 1 = A-B, computed as A+~B+1.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  final carry out; for sub, 1 = no borrow.
REQ-014 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: in_valid=1 at a rising edge = accept; latch a, b (inverted if sub), carry init (cin, or 1 if sub); bit counter=0; go to RUN.
REQ-017 RUN: each edge adds one bit pair LSB-first with registered carry, shifts the result bit into sum, increments the counter.
REQ-018 RUN->DONE on the edge that processes bit WIDTH-1; out_valid rises after the WIDTH-th edge following the accepting edge.
REQ-019 Bit counter width $clog2(WIDTH), minimum 1; no wrap-around beyond WIDTH-1.
REQ-020 DONE: sum, cout, overflow held stable until out_valid&&out_ready at an edge, then go to IDLE.
REQ-021 No bypass: in_ready stays 0 in the cycle the result is consumed; the next accept is one edge later at the earliest.
REQ-022 a, b, cin, sub are ignored outside the accepting edge; changes during RUN have no effect.
REQ-023 WIDTH=1: RUN lasts exactly one edge; overflow = carry-in XOR cout.
REQ-024 Throughput: one operation per WIDTH+2 cycles when out_ready is held high.

Reset
REQ-025 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
REQ-026 Reset asserted during RUN or DONE aborts the operation; no partial result is ever presented.
REQ-027 Reset release is synchronised to clk externally; the first accept may occur on the first edge after release.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the MAX_WIDTH=64 constant.
REQ-029 The one-bit add SHALL be a combinational sub-module, full_adder_cell (a, b, cin -> s, cout), instantiated once.
REQ-030 Control FSM, shift registers and counter SHALL live in serial_adder; there are no other sub-modules.

Verification (WIDTH=8 unless stated)
REQ-031 a=8'h0F, b=8'h01, cin=0, sub=0 -> sum=8'h10, cout=0, overflow=0; out_valid exactly 8 edges after accept.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; a=8'h7F, b=8'h01 -> sum=8'h80, overflow=1.
REQ-033 sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, overflow=0; a=8'h80, b=8'h01 -> sum=8'h7F, overflow=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> sum/cout/overflow stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 rst_n pulsed low at RUN bit 3 -> all outputs at reset values immediately; new op 8'h01+8'h01 then gives 8'h02.
REQ-036 WIDTH=1: a=1, b=1, cin=0 -> sum=0, cout=1, overflow=1; out_valid one edge after accept.
